// File: rtl/odo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : odo_pkg
//  Purpose  : Shared widths and sequencer state encoding for the Odo round
//             datapath.
//  Revision : 1.0  initial release
// ============================================================================
package odo_pkg;

  localparam int ODO_STATE_W = 640;
  localparam int ODO_RK_W    = 10;
  localparam int ODO_ROUNDS  = 84;

  // Sequencer FSM encoding
  localparam int SEQ_ST_W = 2;
  typedef logic [SEQ_ST_W-1:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_RUN  = 2'd1;
  localparam seq_state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/odo_round_key_mux.sv
`default_nettype none
// ============================================================================
//  Module   : odo_round_key_mux
//  Purpose  : Selects the 10-bit round key for the current round index out of
//             the packed key schedule.
//  Revision : 1.0  initial release
// ============================================================================
module odo_round_key_mux
  import odo_pkg::*;
#(
  parameter int ROUNDS = ODO_ROUNDS,
  parameter int RIDX_W = 7
) (
  input  logic [ROUNDS*ODO_RK_W-1:0] key_reg,
  input  logic [RIDX_W-1:0]          round_idx,
  output logic [ODO_RK_W-1:0]        key
);

  logic [ODO_RK_W-1:0] slices [ROUNDS];

  // Break the flat schedule into one fixed-width slice per round
  for (genvar r = 0; r < ROUNDS; r++) begin : g_slice
    assign slices[r] = key_reg[r*ODO_RK_W +: ODO_RK_W];
  end

  // Pick the slice for the active round; indices past the schedule give 0
  always_comb begin
    key = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (round_idx == RIDX_W'(r)) key = slices[r];
    end
  end

endmodule
`default_nettype wire

// File: rtl/odo_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : odo_round_sequencer
//  Purpose  : Iterates one Odo state through ROUNDS passes of an external
//             odo_full_round, waiting ROUND_LAT cycles per pass, then offers
//             the result on a valid/ready output. One job in flight.
//  Revision : 1.0  initial release
// ============================================================================
module odo_round_sequencer
  import odo_pkg::*;
#(
  parameter int ROUNDS    = ODO_ROUNDS,
  parameter int ROUND_LAT = 1,
  parameter int RIDX_W    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ODO_STATE_W-1:0]        in_state,
  input  logic [ROUNDS*ODO_RK_W-1:0]    in_keys,
  output logic [ODO_RK_W-1:0]           rnd_key,
  output logic [ODO_STATE_W-1:0]        rnd_in,
  input  logic [ODO_STATE_W-1:0]        rnd_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ODO_STATE_W-1:0]        out_state,
  output logic                          busy
);

  // Wait counter only needs to reach ROUND_LAT; keep at least one bit
  localparam int                 WCNT_W    = (ROUND_LAT > 0) ? $clog2(ROUND_LAT + 1) : 1;
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(ROUND_LAT);
  localparam logic [RIDX_W-1:0]  RIDX_LAST = RIDX_W'(ROUNDS - 1);

  seq_state_t                     state;
  seq_state_t                     state_nxt;
  logic [ODO_STATE_W-1:0]         state_reg;
  logic [ROUNDS*ODO_RK_W-1:0]     key_reg;
  logic [RIDX_W-1:0]              round_idx;
  logic [WCNT_W-1:0]              wait_cnt;
  logic                           round_done;
  logic                           last_round;

  // A round completes on the cycle the round output has had ROUND_LAT cycles to settle
  assign round_done = (state == ST_RUN) && (wait_cnt == WCNT_LAST);
  assign last_round = (round_idx == RIDX_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)                 state_nxt = ST_RUN;
      ST_RUN:  if (round_done && last_round) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)                state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  // Job capture, per-round recirculation and round/wait counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      round_idx <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state_reg <= in_state;
            key_reg   <= in_keys;
            round_idx <= '0;
            wait_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (round_done) begin
            state_reg <= rnd_out;
            wait_cnt  <= '0;
            // Index stops at the last round so it never wraps
            if (!last_round) round_idx <= round_idx + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  odo_round_key_mux #(
    .ROUNDS (ROUNDS),
    .RIDX_W (RIDX_W)
  ) u_key_mux (
    .key_reg   (key_reg),
    .round_idx (round_idx),
    .key       (rnd_key)
  );

  // Round input and result both come straight from the held state, so they
  // stay stable across a whole round and while the result waits in DONE
  assign rnd_in    = state_reg;
  assign out_state = state_reg;

endmodule
`default_nettype wire

// File: tb/tb_odo_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odo_round_sequencer
//  Purpose  : Directed self-checking bench for odo_round_sequencer using a
//             stub round (rnd_out = rnd_in + key).
//  Revision : 1.0  initial release
// ============================================================================
module tb_odo_round_sequencer;

  localparam int W = 640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: ROUNDS=3, ROUND_LAT=1 with a one-register stub round
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [W-1:0]  a_in_state, a_rnd_in, a_rnd_out, a_out_state, a_stub_q;
  logic [29:0]   a_in_keys;
  logic [9:0]    a_rnd_key;

  // Instance B: ROUNDS=1, ROUND_LAT=0 with a combinational stub round
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [W-1:0]  b_in_state, b_rnd_in, b_rnd_out, b_out_state;
  logic [9:0]    b_in_keys;
  logic [9:0]    b_rnd_key;

  always @(posedge clk) a_stub_q <= a_rnd_in + {630'b0, a_rnd_key};
  assign a_rnd_out = a_stub_q;
  assign b_rnd_out = b_rnd_in + {630'b0, b_rnd_key};

  odo_round_sequencer #(.ROUNDS(3), .ROUND_LAT(1), .RIDX_W(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_state  (a_in_state),
    .in_keys   (a_in_keys),
    .rnd_key   (a_rnd_key),
    .rnd_in    (a_rnd_in),
    .rnd_out   (a_rnd_out),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_state (a_out_state),
    .busy      (a_busy)
  );

  odo_round_sequencer #(.ROUNDS(1), .ROUND_LAT(0), .RIDX_W(1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_state  (b_in_state),
    .in_keys   (b_in_keys),
    .rnd_key   (b_rnd_key),
    .rnd_in    (b_rnd_in),
    .rnd_out   (b_rnd_out),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_state (b_out_state),
    .busy      (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job to A; returns #1 after the accept edge
  task automatic a_start(input logic [W-1:0] st, input logic [29:0] k);
    a_in_state = st;
    a_in_keys  = k;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  // Cycles until out_valid is seen, bounded
  task automatic a_wait_done(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic a_handshake();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  int lat;
  int n_ev;
  int last_ev;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_state = '0; a_in_keys = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_state = '0; b_in_keys = '0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_rnd_in", a_rnd_in, 0);
    check("rst_rnd_key", a_rnd_key, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    rst = 1'b0;
    tick();

    // 1: basic job 5 + 1 + 2 + 3 = 11 after 6 cycles
    a_start(640'd5, {10'd3, 10'd2, 10'd1});
    check("s1_busy", a_busy, 1);
    check("s1_in_ready", a_in_ready, 0);
    check("s1_rnd_in", a_rnd_in, 5);
    check("s1_rnd_key0", a_rnd_key, 1);
    a_wait_done(lat);
    check("s1_latency", lat, 6);
    check("s1_out_state", a_out_state, 11);
    a_handshake();
    check("s1_post_out_valid", a_out_valid, 0);
    check("s1_post_in_ready", a_in_ready, 1);
    check("s1_post_busy", a_busy, 0);
    check("s1_idle_rnd_key", a_rnd_key, 3);
    check("s1_idle_rnd_in", a_rnd_in, 11);

    // 2: single round, zero latency
    b_in_state = '0;
    b_in_keys  = 10'h3FF;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("s2_latency", lat, 1);
    check("s2_out_state", b_out_state, 640'h3FF);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check("s2_post_in_ready", b_in_ready, 1);

    // 3: backpressure, 100 + 10 + 20 + 30 = 160 held for 10 cycles
    a_start(640'd100, {10'd30, 10'd20, 10'd10});
    a_wait_done(lat);
    check("s3_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      check("s3_hold_valid", a_out_valid, 1);
      check("s3_hold_state", a_out_state, 160);
      check("s3_hold_in_ready", a_in_ready, 0);
      tick();
    end
    a_handshake();
    check("s3_post_out_valid", a_out_valid, 0);

    // 4: in_valid during RUN is ignored
    a_start(640'd5, {10'd3, 10'd2, 10'd1});
    a_in_state = 640'd999;
    a_in_valid = 1'b1;
    tick();
    tick();
    a_in_valid = 1'b0;
    a_wait_done(lat);
    check("s4_latency", lat + 2, 6);
    check("s4_out_state", a_out_state, 11);
    a_handshake();

    // 5: reset during round 1, then a clean job 7 + 6 + 5 + 4 = 22
    a_start(640'd50, {10'd1, 10'd1, 10'd1});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_in_ready", a_in_ready, 1);
    check("s5_out_valid", a_out_valid, 0);
    check("s5_busy", a_busy, 0);
    check("s5_rnd_in", a_rnd_in, 0);
    a_start(640'd7, {10'd4, 10'd5, 10'd6});
    check("s5_rnd_key0", a_rnd_key, 6);
    a_wait_done(lat);
    check("s5_latency", lat, 6);
    check("s5_out_state", a_out_state, 22);
    a_handshake();

    // 6: three back-to-back jobs, 1 + 1 + 1 + 1 = 4, spacing 3*(1+1)+2 = 8
    a_in_state  = 640'd1;
    a_in_keys   = {10'd1, 10'd1, 10'd1};
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    n_ev = 0;
    last_ev = 0;
    for (int c = 1; c <= 60 && n_ev < 3; c++) begin
      tick();
      if (a_out_valid) begin
        check("s6_out_state", a_out_state, 4);
        if (n_ev > 0) check("s6_spacing", c - last_ev, 8);
        last_ev = c;
        n_ev++;
      end
    end
    a_in_valid  = 1'b0;
    check("s6_job_count", n_ev, 3);
    tick();
    a_out_ready = 1'b0;
    tick();
    check("s6_final_in_ready", a_in_ready, 1);
    check("s6_final_out_valid", a_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
